counter_seq_ctrl: RTL and testbench

//   Sequencing controller for the free-running 4-bit counter datapath. It adds start/stop

---
 rtl/counter_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_counter_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// Start/stop sequencer for a WIDTH-bit counter with latched terminal count, one-shot or
// auto-reload modes and a registered done pulse. Optional tick prescaler: COUNTER_PRESCALE_EN.
module counter_seq_ctrl #(
    parameter int WIDTH = 4
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int PRE_W = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_auto,
    input  logic [WIDTH-1:0] period,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [WIDTH-1:0] r_period;
    logic             r_mode;
    logic             w_load;
    logic             w_tick;

`ifdef COUNTER_PRESCALE_EN
    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] r_div;

    assign w_tick = (r_pre == r_div);

    // Prescaler restarts whenever a tick fires, a run is loaded, or the FSM heads to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_div <= '0;
        end else begin
            if (w_load)
                r_div <= prescale;
            if (w_load || w_tick || (w_state_nxt != S_RUN))
                r_pre <= '0;
            else
                r_pre <= r_pre + PRE_W'(1);
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_q      <= '0;
            r_done   <= 1'b0;
            r_period <= '0;
            r_mode   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_period <= period;
                r_mode   <= mode_auto;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop && (period != '0)) begin
                    w_load      = 1'b1;
                    w_q_nxt     = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // stop outranks a coincident terminal tick, so no done in that case
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    if (r_q == r_period) begin
                        w_done_nxt = 1'b1;
                        if (r_mode)
                            w_q_nxt = '0;
                        else
                            w_state_nxt = S_IDLE;
                    end else begin
                        w_q_nxt = r_q + WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign q     = r_q;
    assign busy  = (r_state == S_RUN);
    assign done  = r_done;
    assign state = r_state;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: directed steps followed by random stimulus,
// compared against a tick-arithmetic reference model.
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode_auto;
    logic [3:0] period;
`ifdef COUNTER_PRESCALE_EN
    logic [3:0] prescale;
`endif
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic [1:0] state;

    always #5 clk = ~clk;

    counter_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode_auto (mode_auto),
        .period    (period),
`ifdef COUNTER_PRESCALE_EN
        .prescale  (prescale),
`endif
        .q         (q),
        .busy      (busy),
        .done      (done),
        .state     (state)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a run is described by the number of clock edges k since the start
    // edge; ticks t = k / (D+1), and the count is t folded by the period.
    bit m_run;
    bit m_auto;
    bit m_done;
    int m_k;
    int m_p;
    int m_d;
    int m_q;
    int d_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_auto = 0;
        m_done = 0;
        m_k    = 0;
        m_p    = 0;
        m_d    = 0;
        m_q    = 0;
    endtask

    task automatic model_step();
        int  t;
        bit  tk;
        if (!m_run) begin
            m_done = 0;
            if (start && !stop && (period != 4'd0)) begin
                m_run  = 1;
                m_k    = 0;
                m_p    = int'(period);
                m_auto = mode_auto;
                m_d    = d_in;
                m_q    = 0;
            end
        end else if (stop) begin
            m_run  = 0;
            m_done = 0;
        end else begin
            m_k++;
            t  = m_k / (m_d + 1);
            tk = ((m_k % (m_d + 1)) == 0);
            if (m_auto) begin
                m_q    = t % (m_p + 1);
                m_done = tk && ((t % (m_p + 1)) == 0);
            end else if (tk && (t == m_p + 1)) begin
                m_done = 1;
                m_run  = 0;
                m_q    = m_p;
            end else begin
                m_done = 0;
                m_q    = t;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".q"},     32'(q),     32'(m_q));
        chk({tag, ".busy"},  32'(busy),  32'(m_run));
        chk({tag, ".done"},  32'(done),  32'(m_done));
        chk({tag, ".state"}, 32'(state), m_run ? 32'd1 : 32'd0);
    endtask

    task automatic step(input string tag, input logic s, input logic st, input logic ma,
                        input logic [3:0] p, input int d);
        start     = s;
        stop      = st;
        mode_auto = ma;
        period    = p;
`ifdef COUNTER_PRESCALE_EN
        prescale  = d[3:0];
        d_in      = d;
`else
        d_in      = 0 * d;
`endif
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outs(tag);
    endtask

    initial begin
        int cnt;
        bit found;
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        mode_auto = 1'b0;
        period    = 4'd0;
        d_in      = 0;
`ifdef COUNTER_PRESCALE_EN
        prescale  = 4'd0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check_outs("reset");
        rst_n = 1'b1;

        // one-shot, P=3
        step("os_start", 1, 0, 0, 4'd3, 0);
        chk("os_q0", 32'(q), 0);
        chk("os_busy0", 32'(busy), 1);
        for (int i = 1; i <= 3; i++) begin
            step("os_run", 0, 0, 1, 4'd9, 0);
            chk("os_q", 32'(q), 32'(i));
            chk("os_nodone", 32'(done), 0);
        end
        step("os_term", 0, 0, 0, 4'd3, 0);
        chk("os_done", 32'(done), 1);
        chk("os_busy_end", 32'(busy), 0);
        chk("os_q_hold", 32'(q), 3);
        step("os_after", 0, 0, 0, 4'd3, 0);
        chk("os_done_once", 32'(done), 0);
        chk("os_q_hold2", 32'(q), 3);

        // auto-reload, P=2; period changes mid-run must be ignored
        step("ar_start", 1, 0, 1, 4'd2, 0);
        for (int k = 1; k <= 8; k++) begin
            step("ar_run", 0, 0, 0, 4'd9, 0);
            chk("ar_q", 32'(q), 32'(k % 3));
            chk("ar_done", 32'(done), (k % 3 == 0) ? 32'd1 : 32'd0);
            chk("ar_busy", 32'(busy), 1);
        end
        step("ar_restart_ignored", 1, 0, 0, 4'd7, 0);
        step("ar_stop", 0, 1, 1, 4'd2, 0);
        chk("ar_stop_state", 32'(state), 0);

        // asynchronous reset in the middle of a run
        step("rr_start", 1, 0, 1, 4'd4, 0);
        step("rr_run", 0, 0, 1, 4'd4, 0);
        step("rr_run", 0, 0, 1, 4'd4, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_q", 32'(q), 0);
        chk("rr_busy", 32'(busy), 0);
        chk("rr_done", 32'(done), 0);
        chk("rr_state", 32'(state), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_outs("rr_post");

        // stop on the terminal tick, P=5
        step("sp_start", 1, 0, 0, 4'd5, 0);
        repeat (5) step("sp_run", 0, 0, 0, 4'd5, 0);
        chk("sp_q5", 32'(q), 5);
        step("sp_stop", 0, 1, 0, 4'd5, 0);
        chk("sp_state", 32'(state), 0);
        chk("sp_q", 32'(q), 5);
        chk("sp_done", 32'(done), 0);
        step("sp_after", 0, 0, 0, 4'd5, 0);
        chk("sp_done2", 32'(done), 0);

        // edge cases: P=0 ignored, start+stop ignored
        step("p0", 1, 0, 0, 4'd0, 0);
        chk("p0_state", 32'(state), 0);
        chk("p0_q", 32'(q), 5);
        step("ss", 1, 1, 0, 4'd7, 0);
        chk("ss_state", 32'(state), 0);
        chk("ss_q", 32'(q), 5);

        // P=15 one-shot: done after 16 ticks
        step("p15_start", 1, 0, 0, 4'd15, 0);
        cnt   = 0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                step("p15_run", 0, 0, 0, 4'd15, 0);
                cnt++;
                if (done === 1'b1) found = 1;
            end
        end
        chk("p15_ticks", 32'(cnt), 16);
        chk("p15_q", 32'(q), 15);

`ifdef COUNTER_PRESCALE_EN
        // D=2, P=1 one-shot: q steps every 3 clks, done 6 clks after start
        step("ps_start", 1, 0, 0, 4'd1, 2);
        for (int c = 1; c <= 6; c++) begin
            step("ps_run", 0, 0, 0, 4'd1, 2);
            chk("ps_q", 32'(q), (c < 6) ? 32'(c / 3) : 32'd1);
            chk("ps_done", 32'(done), (c == 6) ? 32'd1 : 32'd0);
        end
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom % 4) == 0,
                 ($urandom % 16) == 0,
                 1'($urandom % 2),
                 4'($urandom % 16),
                 int'($urandom % 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
